axis_downsizer: RTL and testbench

AXIS_DOWNSIZER -- requirements
Module: axis_downsizer

---
 rtl/axis_pkg.sv | 24 ++
 rtl/axis_downsizer_if.sv | 44 ++++
 rtl/axis_downsizer_prio_enc.sv | 36 +++
 rtl/axis_downsizer.sv | 135 +++++++++++++
 tb/tb_axis_downsizer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkg.sv
// ============================================================================
// Module      : axis_pkg
// Description : Shared AXI-Stream definitions: downsizer FSM state encoding
//               and legal beat-size limits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_pkg;

    // Holding-register state of the downsizer.
    // IDLE: nothing left to send; SERIAL: unsent words remain.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SERIAL = 1'b1
    } axis_state_e;

    // Legal range for the number of narrow words per wide beat.
    localparam int C_WORDS_MIN = 2;
    localparam int C_WORDS_MAX = 16;

endpackage : axis_pkg

`default_nettype wire

// File: rtl/axis_downsizer_if.sv
// ============================================================================
// Module      : axis_downsizer_if
// Description : One AXI-Stream channel (data, keep, valid, ready, last, user)
//               with master (driver) and slave (receiver) views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axis_downsizer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4,
    parameter int USER_WIDTH = 1
);

    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    // Side that produces the stream.
    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    // Side that consumes the stream.
    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface : axis_downsizer_if

`default_nettype wire

// File: rtl/axis_downsizer_prio_enc.sv
// ============================================================================
// Module      : axis_downsizer_prio_enc
// Description : Picks the next word to emit from the pending mask: index of
//               the lowest set bit, whether any bit is set, and whether that
//               bit is the only one left (the final word of the beat).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_downsizer_prio_enc #(
    parameter int WORDS = 4,
    parameter int IDX_W = 2
) (
    input  wire logic [WORDS-1:0] mask_i,
    output logic      [IDX_W-1:0] idx_o,
    output logic                  any_o,
    output logic                  is_last_o
);

    // Scan from the top down so the lowest set bit is the one that sticks.
    always_comb begin
        idx_o = '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = i[IDX_W-1:0];
            end
        end
    end

    // Clearing the lowest set bit leaves zero only when exactly one bit is set.
    assign any_o     = |mask_i;
    assign is_last_o = any_o && ((mask_i & (mask_i - WORDS'(1))) == '0);

endmodule : axis_downsizer_prio_enc

`default_nettype wire

// File: rtl/axis_downsizer.sv
// ============================================================================
// Module      : axis_downsizer
// Description : Serialises a wide AXI-Stream beat of WORDS words into WORDS
//               narrow beats, lowest word first, one word per cycle. A new
//               wide beat is accepted in the same cycle the last word leaves
//               so back-to-back beats stream without bubbles.
//               Build option: define AXIS_DOWNSIZER_KEEP_EN to honour tkeep
//               (skip null words, tlast on the highest kept word); without it
//               tkeep is ignored and every word is sent.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_downsizer
    import axis_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int WORDS      = 4,
    parameter int USER_WIDTH = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    axis_downsizer_if.slave    s_axis,
    axis_downsizer_if.master   m_axis
);

    localparam int IDX_W  = $clog2(WORDS);
    localparam int BEAT_W = WORDS * WORD_WIDTH;

    // Reject out-of-range beat sizes at elaboration.
    if (WORDS < C_WORDS_MIN || WORDS > C_WORDS_MAX) begin : g_words_range_check
        $error("axis_downsizer: WORDS must be in 2..16");
    end

    // ------------------------------------------------------------------
    // Holding register and its next-state values
    // ------------------------------------------------------------------
    axis_state_e             state_q, state_d;
    logic [BEAT_W-1:0]       data_q,  data_d;
    logic [WORDS-1:0]        mask_q,  mask_d;
    logic                    last_q,  last_d;
    logic [USER_WIDTH-1:0]   user_q,  user_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]        w_idx;
    logic                    w_any;
    logic                    w_is_last;
    logic [WORDS-1:0]        w_new_mask;
    logic [WORD_WIDTH-1:0]   w_word;
    logic                    w_m_valid;
    logic                    w_xfer;
    logic                    w_accept;
    logic                    w_s_ready;

    axis_downsizer_prio_enc #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .mask_i    (mask_q),
        .idx_o     (w_idx),
        .any_o     (w_any),
        .is_last_o (w_is_last)
    );

`ifdef AXIS_DOWNSIZER_KEEP_EN
    // Only words flagged by tkeep are sent; an all-zero keep sends nothing.
    assign w_new_mask = s_axis.tkeep;
`else
    // Every word of every beat is sent; tkeep has no effect.
    logic w_unused_keep;
    assign w_unused_keep = &{1'b0, s_axis.tkeep};
    assign w_new_mask    = '1;
`endif

    // SERIAL always implies a non-empty mask, so state alone gives valid.
    assign w_m_valid = (state_q == SERIAL) && w_any;
    assign w_xfer    = w_m_valid && m_axis.tready;

    // Ready when empty, or when the final pending word leaves this cycle.
    assign w_s_ready = !rst && ((state_q == IDLE) || (w_xfer && w_is_last));
    assign w_accept  = s_axis.tvalid && w_s_ready;

    assign w_word = data_q[w_idx*WORD_WIDTH +: WORD_WIDTH];

    // Outputs are forced to zero when idle so reset leaves a clean bus.
    assign s_axis.tready = w_s_ready;
    assign m_axis.tvalid = w_m_valid;
    assign m_axis.tdata  = w_m_valid ? w_word : '0;
    assign m_axis.tlast  = w_m_valid && last_q && w_is_last;
    assign m_axis.tuser  = w_m_valid ? user_q : '0;
    assign m_axis.tkeep  = '1;

    // Next-state: load a new beat on accept, otherwise retire the sent word.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mask_d  = mask_q;
        last_d  = last_q;
        user_d  = user_q;
        if (w_accept) begin
            data_d  = s_axis.tdata;
            mask_d  = w_new_mask;
            last_d  = s_axis.tlast;
            user_d  = s_axis.tuser;
            state_d = (w_new_mask != '0) ? SERIAL : IDLE;
        end else if (w_xfer) begin
            mask_d = mask_q & ~(WORDS'(1) << w_idx);
            if (w_is_last) begin
                state_d = IDLE;
            end
        end
    end

    // Holding register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
            user_q  <= user_d;
        end
    end

endmodule : axis_downsizer

`default_nettype wire

// File: tb/tb_axis_downsizer.sv
// ============================================================================
// Module      : tb_axis_downsizer
// Description : Directed self-checking bench for axis_downsizer (WORDS=4,
//               WORD_WIDTH=8). The keep scenario follows the
//               AXIS_DOWNSIZER_KEEP_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_downsizer;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    axis_downsizer_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(1)) s_if ();
    axis_downsizer_if #(.DATA_WIDTH(8),  .KEEP_WIDTH(1), .USER_WIDTH(1)) m_if ();

    axis_downsizer #(
        .WORD_WIDTH (8),
        .WORDS      (4),
        .USER_WIDTH (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s_axis (s_if),
        .m_axis (m_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [31:0] data, input logic [3:0] keep,
                              input logic last, input logic user);
        s_if.tvalid = 1'b1;
        s_if.tdata  = data;
        s_if.tkeep  = keep;
        s_if.tlast  = last;
        s_if.tuser  = user;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        step();
        step();
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b expected 0", m_if.tvalid); end
        n_cmp++; if (m_if.tdata !== 8'h00) begin n_err++; $display("FAIL reset_tdata: got %h expected 00", m_if.tdata); end
        n_cmp++; if (m_if.tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %b expected 0", m_if.tlast); end
        n_cmp++; if (m_if.tuser !== 1'b0) begin n_err++; $display("FAIL reset_tuser: got %b expected 0", m_if.tuser); end
        n_cmp++; if (s_if.tready !== 1'b0) begin n_err++; $display("FAIL reset_s_tready: got %b expected 0", s_if.tready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL post_reset_s_tready: got %b expected 1", s_if.tready); end
        step();
    endtask

    task automatic test_single_beat();
        logic [7:0] exp_w [4];
        exp_w = '{8'h11, 8'h22, 8'h33, 8'h44};
        drive_beat(32'h44332211, 4'hF, 1'b1, 1'b1);
        m_if.tready = 1'b1;
        #1;
        n_cmp++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL single_accept_ready: got %b expected 1", s_if.tready); end
        step();
        s_if.tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (m_if.tvalid !== 1'b1) begin n_err++; $display("FAIL single_tvalid[%0d]: got %b expected 1", k, m_if.tvalid); end
            n_cmp++; if (m_if.tdata !== exp_w[k]) begin n_err++; $display("FAIL single_tdata[%0d]: got %h expected %h", k, m_if.tdata, exp_w[k]); end
            n_cmp++; if (m_if.tlast !== (k == 3)) begin n_err++; $display("FAIL single_tlast[%0d]: got %b expected %b", k, m_if.tlast, (k == 3)); end
            n_cmp++; if (m_if.tuser !== 1'b1) begin n_err++; $display("FAIL single_tuser[%0d]: got %b expected 1", k, m_if.tuser); end
            step();
        end
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL single_idle_after: got %b expected 0", m_if.tvalid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_w [4];
        int widx;
        exp_w = '{8'h11, 8'h22, 8'h33, 8'h44};
        widx = 0;
        drive_beat(32'h44332211, 4'hF, 1'b1, 1'b0);
        m_if.tready = 1'b0;
        step();
        s_if.tvalid = 1'b0;
        for (int cyc = 0; cyc < 30 && widx < 4; cyc++) begin
            m_if.tready = (cyc % 3 == 0);
            #1;
            n_cmp++; if (m_if.tvalid !== 1'b1) begin n_err++; $display("FAIL bp_tvalid[c%0d]: got %b expected 1", cyc, m_if.tvalid); end
            n_cmp++; if (m_if.tdata !== exp_w[widx]) begin n_err++; $display("FAIL bp_tdata[c%0d]: got %h expected %h", cyc, m_if.tdata, exp_w[widx]); end
            n_cmp++; if (m_if.tlast !== (widx == 3)) begin n_err++; $display("FAIL bp_tlast[c%0d]: got %b expected %b", cyc, m_if.tlast, (widx == 3)); end
            n_cmp++; if (s_if.tready !== (m_if.tready && widx == 3)) begin n_err++; $display("FAIL bp_s_tready[c%0d]: got %b expected %b", cyc, s_if.tready, (m_if.tready && widx == 3)); end
            if (m_if.tready) widx++;
            step();
        end
        n_cmp++; if (widx !== 4) begin n_err++; $display("FAIL bp_word_count: got %0d expected 4", widx); end
        m_if.tready = 1'b1;
        #1;
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL bp_idle_after: got %b expected 0", m_if.tvalid); end
        step();
    endtask

`ifdef AXIS_DOWNSIZER_KEEP_EN
    task automatic test_keep();
        drive_beat(32'hDDCCBBAA, 4'b0101, 1'b1, 1'b0);
        m_if.tready = 1'b1;
        step();
        s_if.tvalid = 1'b0;
        #1;
        n_cmp++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 8'hAA || m_if.tlast !== 1'b0) begin n_err++; $display("FAIL keep_word0: got v=%b d=%h l=%b expected v=1 d=aa l=0", m_if.tvalid, m_if.tdata, m_if.tlast); end
        step();
        n_cmp++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 8'hCC || m_if.tlast !== 1'b1) begin n_err++; $display("FAIL keep_word1: got v=%b d=%h l=%b expected v=1 d=cc l=1", m_if.tvalid, m_if.tdata, m_if.tlast); end
        n_cmp++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL keep_final_ready: got %b expected 1", s_if.tready); end
        step();
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL keep_idle_after: got %b expected 0", m_if.tvalid); end
        // Null beat: consumed in one cycle with no output.
        drive_beat(32'h12345678, 4'b0000, 1'b1, 1'b0);
        #1;
        n_cmp++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL keep_null_ready: got %b expected 1", s_if.tready); end
        step();
        s_if.tvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL keep_null_no_output[%0d]: got %b expected 0", k, m_if.tvalid); end
            n_cmp++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL keep_null_ready_after[%0d]: got %b expected 1", k, s_if.tready); end
            step();
        end
    endtask
`else
    task automatic test_keep();
        logic [7:0] exp_w [4];
        exp_w = '{8'h01, 8'h02, 8'h03, 8'h04};
        drive_beat(32'h04030201, 4'b0000, 1'b1, 1'b0);
        m_if.tready = 1'b1;
        step();
        s_if.tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== exp_w[k]) begin n_err++; $display("FAIL nokeep_word[%0d]: got v=%b d=%h expected v=1 d=%h", k, m_if.tvalid, m_if.tdata, exp_w[k]); end
            n_cmp++; if (m_if.tlast !== (k == 3)) begin n_err++; $display("FAIL nokeep_tlast[%0d]: got %b expected %b", k, m_if.tlast, (k == 3)); end
            step();
        end
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL nokeep_idle_after: got %b expected 0", m_if.tvalid); end
    endtask
`endif

    task automatic test_back_to_back();
        logic [31:0] beats [3];
        logic [7:0]  exp_d;
        int bi;
        int oi;
        int last_cyc;
        logic acc;
        beats    = '{32'h13121110, 32'h23222120, 32'h33323130};
        bi       = 0;
        oi       = 0;
        last_cyc = -1;
        m_if.tready = 1'b1;
        for (int cyc = 0; cyc < 30 && oi < 12; cyc++) begin
            if (bi < 3) drive_beat(beats[bi], 4'hF, (bi == 2), 1'b0);
            else        s_if.tvalid = 1'b0;
            #1;
            acc = s_if.tvalid && s_if.tready;
            if (cyc <= 12) begin
                n_cmp++; if (s_if.tready !== (cyc % 4 == 0)) begin n_err++; $display("FAIL b2b_s_tready[c%0d]: got %b expected %b", cyc, s_if.tready, (cyc % 4 == 0)); end
            end
            if (cyc >= 1) begin
                n_cmp++; if (m_if.tvalid !== 1'b1) begin n_err++; $display("FAIL b2b_gap[c%0d]: got tvalid %b expected 1", cyc, m_if.tvalid); end
            end
            if (m_if.tvalid && m_if.tready) begin
                exp_d = 8'((oi / 4 + 1) * 16 + oi % 4);
                n_cmp++; if (m_if.tdata !== exp_d) begin n_err++; $display("FAIL b2b_tdata[%0d]: got %h expected %h", oi, m_if.tdata, exp_d); end
                n_cmp++; if (m_if.tlast !== (oi == 11)) begin n_err++; $display("FAIL b2b_tlast[%0d]: got %b expected %b", oi, m_if.tlast, (oi == 11)); end
                oi++;
                if (oi == 12) last_cyc = cyc;
            end
            if (acc) bi++;
            step();
        end
        s_if.tvalid = 1'b0;
        n_cmp++; if (oi !== 12) begin n_err++; $display("FAIL b2b_word_count: got %0d expected 12", oi); end
        n_cmp++; if (last_cyc + 1 !== 13) begin n_err++; $display("FAIL b2b_cycles: got %0d expected 13", last_cyc + 1); end
        #1;
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL b2b_idle_after: got %b expected 0", m_if.tvalid); end
        step();
    endtask

    task automatic test_reset_mid_beat();
        logic [7:0] exp_w [4];
        exp_w = '{8'h55, 8'h66, 8'h77, 8'h88};
        drive_beat(32'h44332211, 4'hF, 1'b1, 1'b0);
        m_if.tready = 1'b1;
        step();
        s_if.tvalid = 1'b0;
        #1;
        n_cmp++; if (m_if.tdata !== 8'h11) begin n_err++; $display("FAIL rstmid_word0: got %h expected 11", m_if.tdata); end
        step();
        n_cmp++; if (m_if.tdata !== 8'h22) begin n_err++; $display("FAIL rstmid_word1: got %h expected 22", m_if.tdata); end
        step();
        rst = 1'b1;
        step();
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_tvalid: got %b expected 0", m_if.tvalid); end
        n_cmp++; if (s_if.tready !== 1'b0) begin n_err++; $display("FAIL rstmid_s_tready: got %b expected 0", s_if.tready); end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_residual[%0d]: got %b expected 0", k, m_if.tvalid); end
            step();
        end
        drive_beat(32'h88776655, 4'hF, 1'b1, 1'b1);
        step();
        s_if.tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== exp_w[k] || m_if.tuser !== 1'b1) begin n_err++; $display("FAIL rstmid_fresh[%0d]: got v=%b d=%h u=%b expected v=1 d=%h u=1", k, m_if.tvalid, m_if.tdata, m_if.tuser, exp_w[k]); end
            n_cmp++; if (m_if.tlast !== (k == 3)) begin n_err++; $display("FAIL rstmid_fresh_tlast[%0d]: got %b expected %b", k, m_if.tlast, (k == 3)); end
            step();
        end
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_idle_after: got %b expected 0", m_if.tvalid); end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = '0;
        m_if.tready = 1'b0;
        test_reset();
        test_single_beat();
        test_backpressure();
        test_keep();
        test_back_to_back();
        test_reset_mid_beat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop in case the sequence above stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_axis_downsizer

`default_nettype wire
